// File: rtl/dot_accumulator_if.sv
// rtl/dot_accumulator_if.sv - Product-stream, result and control signals of the dot-product accumulator
interface dot_accumulator_if #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 3
);

  // Control from the matrix sequencer
  logic              start;
  logic [LEN_W-1:0]  len;
  logic              busy;

  // Product stream from the multiplier
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_prod;
  logic              in_ovf;

  // Result stream to writeback
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_sum;
  logic              out_ovf;

  // Sequencer / multiplier / writeback side
  modport master (
    output start, len, in_valid, in_prod, in_ovf, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf, busy
  );

  // Accumulator side
  modport slave (
    input  start, len, in_valid, in_prod, in_ovf, out_ready,
    output in_ready, out_valid, out_sum, out_ovf, busy
  );

endinterface

// File: rtl/dot_accumulator.sv
// rtl/dot_accumulator.sv - Accumulates a run-time count of signed products into one 8-bit result (option: ACC_SATURATE_EN)
module dot_accumulator #(
  parameter int DATA_W = 8,
  parameter int DIM    = 5,
  parameter int LEN_W  = 3,
  parameter int ACC_W  = 12
) (
  input  logic            clk,
  input  logic            rst,
  dot_accumulator_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Signed bounds of the DATA_W-bit result, held at accumulator width
  localparam logic signed [ACC_W-1:0] SUM_MAX = ACC_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SUM_MIN = ~SUM_MAX;
  localparam logic [LEN_W-1:0]        DIM_L   = LEN_W'(DIM);

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [LEN_W-1:0]         cnt_q, cnt_d;
  logic [LEN_W-1:0]         len_q, len_d;
  logic                     sticky_q, sticky_d;
  logic [DATA_W-1:0]        sum_q, sum_d;
  logic                     ovf_q, ovf_d;

  logic [LEN_W-1:0]         len_eff;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_add;
  logic [LEN_W-1:0]         cnt_inc;
  logic                     rng_hi;
  logic                     rng_lo;
  logic [DATA_W-1:0]        res_sum;
  logic                     load;

  // Requests longer than the matrix dimension are clamped to DIM
  assign len_eff  = (bus.len > DIM_L) ? DIM_L : bus.len;

  // Sign-extend the incoming product and form the candidate running sum
  assign prod_ext = {{(ACC_W - DATA_W){bus.in_prod[DATA_W-1]}}, bus.in_prod};
  assign acc_add  = acc_q + prod_ext;
  assign cnt_inc  = cnt_q + LEN_W'(1);

  // Range check of the sum including the beat being accepted
  assign rng_hi   = (acc_add > SUM_MAX);
  assign rng_lo   = (acc_add < SUM_MIN);

`ifdef ACC_SATURATE_EN
  // Clamp out-of-range sums to the nearest representable value
  assign res_sum  = rng_hi ? {1'b0, {(DATA_W - 1){1'b1}}} :
                    rng_lo ? {1'b1, {(DATA_W - 1){1'b0}}} :
                             acc_add[DATA_W-1:0];
`else
  // Two's-complement wrap: keep the low DATA_W bits
  assign res_sum  = acc_add[DATA_W-1:0];
`endif

  // A new dot product may start from IDLE, or straight from DONE as the
  // current result is consumed (back-to-back, skipping IDLE)
  assign load = bus.start &&
                ((state_q == S_IDLE) || ((state_q == S_DONE) && bus.out_ready));

  // Next-state and datapath next values
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    sticky_d = sticky_q;
    sum_d    = sum_q;
    ovf_d    = ovf_q;

    case (state_q)
      S_IDLE: begin
        // Only 'load' can leave IDLE; handled below
      end
      S_ACC: begin
        if (bus.in_valid) begin
          acc_d    = acc_add;
          sticky_d = sticky_q | bus.in_ovf;
          cnt_d    = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d = S_DONE;
            sum_d   = res_sum;
            ovf_d   = sticky_q | bus.in_ovf | rng_hi | rng_lo;
          end
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (load) begin
      len_d    = len_eff;
      acc_d    = '0;
      cnt_d    = '0;
      sticky_d = 1'b0;
      if (len_eff == '0) begin
        // Empty dot product: result is an immediate zero without overflow
        state_d = S_DONE;
        sum_d   = '0;
        ovf_d   = 1'b0;
      end else begin
        state_d = S_ACC;
      end
    end
  end

  // State register; async reset abandons any partial sum
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Accumulator, counters and the held result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
      sticky_q <= 1'b0;
      sum_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      sticky_q <= sticky_d;
      sum_q    <= sum_d;
      ovf_q    <= ovf_d;
    end
  end

  // Handshakes are decoded from state only; the result comes from registers
  assign bus.in_ready  = (state_q == S_ACC);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.out_sum   = sum_q;
  assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_dot_accumulator.sv
// tb/tb_dot_accumulator.sv - Directed self-checking bench for dot_accumulator
module tb_dot_accumulator;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  dot_accumulator_if #(.DATA_W(8), .LEN_W(3)) bus ();

  dot_accumulator #(.DATA_W(8), .DIM(5), .LEN_W(3), .ACC_W(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef ACC_SATURATE_EN
  localparam logic [7:0] POS_SUM = 8'h7F;
  localparam logic [7:0] NEG_SUM = 8'h80;
`else
  localparam logic [7:0] POS_SUM = 8'hF4;
  localparam logic [7:0] NEG_SUM = 8'h70;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic begin_dot(input logic [2:0] n);
    bus.start = 1'b1;
    bus.len   = n;
    tick();
    bus.start = 1'b0;
    bus.len   = 3'd0;
  endtask

  task automatic send(input logic [7:0] p, input logic o);
    bus.in_valid = 1'b1;
    bus.in_prod  = p;
    bus.in_ovf   = o;
    tick();
    bus.in_valid = 1'b0;
    bus.in_prod  = 8'h00;
    bus.in_ovf   = 1'b0;
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic chk_result(input string tag, input logic [7:0] s, input logic o);
    chk({tag, ".valid"}, 16'(bus.out_valid), 16'h1);
    chk({tag, ".sum"},   16'(bus.out_sum),   16'(s));
    chk({tag, ".ovf"},   16'(bus.out_ovf),   16'(o));
  endtask

  initial begin
    pass_cnt      = 0;
    total_cnt     = 0;
    rst           = 1'b0;
    bus.start     = 1'b0;
    bus.len       = 3'd0;
    bus.in_valid  = 1'b0;
    bus.in_prod   = 8'h00;
    bus.in_ovf    = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst.in_ready",  16'(bus.in_ready),  16'h0);
    chk("rst.out_valid", 16'(bus.out_valid), 16'h0);
    chk("rst.out_sum",   16'(bus.out_sum),   16'h0);
    chk("rst.out_ovf",   16'(bus.out_ovf),   16'h0);
    chk("rst.busy",      16'(bus.busy),      16'h0);
    rst = 1'b1;
    tick();

    // Basic sum: -30 + 10 + 5 = -15
    begin_dot(3'd3);
    chk("basic.in_ready", 16'(bus.in_ready), 16'h1);
    chk("basic.busy",     16'(bus.busy),     16'h1);
    send(8'hE2, 1'b0);
    send(8'h0A, 1'b0);
    chk("basic.early_valid", 16'(bus.out_valid), 16'h0);
    send(8'h05, 1'b0);
    chk_result("basic", 8'hF1, 1'b0);
    chk("basic.in_ready_done", 16'(bus.in_ready), 16'h0);
    consume();
    chk("basic.idle_valid", 16'(bus.out_valid), 16'h0);
    chk("basic.idle_busy",  16'(bus.busy),      16'h0);

    // Positive range overflow: 5 x 100 = 500
    begin_dot(3'd5);
    for (int i = 0; i < 5; i++) send(8'h64, 1'b0);
    chk_result("pos", POS_SUM, 1'b1);
    consume();

    // Negative range overflow: 4 x -100 = -400
    begin_dot(3'd4);
    for (int i = 0; i < 4; i++) send(8'h9C, 1'b0);
    chk_result("neg", NEG_SUM, 1'b1);
    consume();

    // Sticky in_ovf with an input stall of two cycles
    begin_dot(3'd2);
    send(8'h03, 1'b1);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("gap.in_ready",  16'(bus.in_ready),  16'h1);
      chk("gap.out_valid", 16'(bus.out_valid), 16'h0);
    end
    send(8'h04, 1'b0);
    chk_result("sticky", 8'h07, 1'b1);

    // Output backpressure; a start while out_ready=0 is ignored
    for (int i = 0; i < 3; i++) begin
      bus.start = (i == 1);
      bus.len   = 3'd1;
      tick();
      chk_result("hold", 8'h07, 1'b1);
      chk("hold.in_ready", 16'(bus.in_ready), 16'h0);
    end
    bus.start = 1'b0;

    // Back-to-back: consume and restart in the same cycle
    bus.out_ready = 1'b1;
    bus.start     = 1'b1;
    bus.len       = 3'd1;
    tick();
    bus.out_ready = 1'b0;
    bus.start     = 1'b0;
    bus.len       = 3'd0;
    chk("b2b.in_ready",  16'(bus.in_ready),  16'h1);
    chk("b2b.out_valid", 16'(bus.out_valid), 16'h0);
    chk("b2b.busy",      16'(bus.busy),      16'h1);
    send(8'h09, 1'b0);
    chk_result("b2b", 8'h09, 1'b0);

    // Async reset mid-operation (result 9 still held going in)
    begin_dot(3'd4);
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    rst = 1'b0;
    #1;
    chk("arst.in_ready",  16'(bus.in_ready),  16'h0);
    chk("arst.out_valid", 16'(bus.out_valid), 16'h0);
    chk("arst.out_sum",   16'(bus.out_sum),   16'h0);
    chk("arst.busy",      16'(bus.busy),      16'h0);
    tick();
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_prod  = 8'h05;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("arst.no_result", 16'(bus.out_valid), 16'h0);
      chk("arst.no_accept", 16'(bus.in_ready),  16'h0);
    end
    bus.in_valid = 1'b0;
    bus.in_prod  = 8'h00;

    // Empty dot product
    begin_dot(3'd0);
    chk_result("len0", 8'h00, 1'b0);
    chk("len0.in_ready", 16'(bus.in_ready), 16'h0);
    consume();

    // len=7 clamps to 5 beats: 5 x 20 = 100
    begin_dot(3'd7);
    for (int i = 0; i < 4; i++) send(8'h14, 1'b0);
    chk("clamp.early_valid", 16'(bus.out_valid), 16'h0);
    chk("clamp.in_ready",    16'(bus.in_ready),  16'h1);
    send(8'h14, 1'b0);
    chk_result("clamp", 8'h64, 1'b0);
    chk("clamp.in_ready_done", 16'(bus.in_ready), 16'h0);

    // Back-to-back into an empty dot product: stays in DONE with zero
    bus.out_ready = 1'b1;
    bus.start     = 1'b1;
    bus.len       = 3'd0;
    tick();
    bus.out_ready = 1'b0;
    bus.start     = 1'b0;
    chk_result("b2b_len0", 8'h00, 1'b0);
    consume();
    chk("end.busy", 16'(bus.busy), 16'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
